// File: rtl/detector_share_arbiter.sv
// -----------------------------------------------------------------------------
// detector_share_arbiter
//
// Round-robin arbiter that time-shares one serial sequence-detector FSM between
// NUM_REQ requesters. The granted requester's serial bit is steered onto the
// detector input. Every grant starts with a one-cycle detector clear, lasts at
// most MAX_HOLD cycles and is followed by exactly one all-idle GAP cycle.
//
// Parameters:
//   NUM_REQ  number of requesters (2..8)
//   MAX_HOLD maximum consecutive cycles in one grant (2..255)
//   CNT_W    hold-counter width, 2**CNT_W > MAX_HOLD
//
// Ports:
//   CLK      clock, rising edge
//   RST      asynchronous reset, active low
//   REQ      per-requester request level
//   BIT_IN   per-requester serial bit
//   LOCK     grant-extension request (only honoured with ARB_LOCK_EN)
//   GNT      one-hot registered grant
//   BUSY     high while any grant is active
//   DET_IN   steered serial bit to the shared detector (combinational)
//   DET_CLR  registered one-cycle clear pulse at the start of each grant
//   OWNER    binary index of the current or last owner
//
// Build option:
//   ARB_LOCK_EN  when defined, LOCK=1 with the owner still requesting
//                suppresses the MAX_HOLD exit; otherwise LOCK is ignored.
// -----------------------------------------------------------------------------
module detector_share_arbiter #(
   parameter int NUM_REQ  = 4,
   parameter int MAX_HOLD = 8,
   parameter int CNT_W    = 8
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic [NUM_REQ-1:0] REQ,
   input  logic [NUM_REQ-1:0] BIT_IN,
   input  logic               LOCK,
   output logic [NUM_REQ-1:0] GNT,
   output logic               BUSY,
   output logic               DET_IN,
   output logic               DET_CLR,
   output logic [2:0]         OWNER
);

   localparam logic [NUM_REQ-1:0] ONE  = NUM_REQ'(1);
   localparam logic [CNT_W-1:0]   HOLD = CNT_W'(MAX_HOLD);
   localparam logic [2:0]         LAST = 3'(NUM_REQ - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GAP   = 2'd2
   } state_t;

   state_t             state, state_n;
   logic [NUM_REQ-1:0] gnt_n;
   logic               busy_n;
   logic               clr_n;
   logic [2:0]         owner_n;
   logic [2:0]         ptr, ptr_n;
   logic [CNT_W-1:0]   cnt, cnt_n;

   logic               found;
   logic [2:0]         win;
   logic [NUM_REQ-1:0] win_oh;
   logic               req_own;
   logic               hold_hit;
   logic               grant_exit;
   logic [2:0]         ptr_adv;

   // Rotating priority search starting at ptr.
   always_comb begin
      int idx;
      found  = 1'b0;
      win    = 3'd0;
      win_oh = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = int'(ptr) + i;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!found && ((REQ & (ONE << idx)) != '0)) begin
            found  = 1'b1;
            win    = 3'(idx);
            win_oh = ONE << idx;
         end
      end
   end

   // GNT is one-hot on OWNER whenever BUSY, so masking with GNT selects the
   // owner's lines and yields 0 outside a grant (including during reset).
   assign req_own  = |(REQ & GNT);
   assign DET_IN   = |(BIT_IN & GNT);
   assign hold_hit = (cnt >= HOLD);
   assign ptr_adv  = (OWNER >= LAST) ? 3'd0 : OWNER + 3'd1;

`ifdef ARB_LOCK_EN
   assign grant_exit = !req_own || (hold_hit && !LOCK);
`else
   logic unused_lock;
   assign unused_lock = LOCK;
   assign grant_exit  = !req_own || hold_hit;
`endif

   always_comb begin
      state_n = state;
      gnt_n   = GNT;
      busy_n  = BUSY;
      clr_n   = 1'b0;
      owner_n = OWNER;
      ptr_n   = ptr;
      cnt_n   = cnt;
      case (state)
         GRANT: begin
            if (grant_exit) begin
               state_n = GAP;
               gnt_n   = '0;
               busy_n  = 1'b0;
               ptr_n   = ptr_adv;
               cnt_n   = '0;
            end else if (!hold_hit) begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         default: begin
            // IDLE and GAP arbitrate identically; GAP only guarantees one idle cycle.
            if (found) begin
               state_n = GRANT;
               gnt_n   = win_oh;
               busy_n  = 1'b1;
               clr_n   = 1'b1;
               owner_n = win;
               cnt_n   = CNT_W'(1);
            end else begin
               state_n = IDLE;
               gnt_n   = '0;
               busy_n  = 1'b0;
               cnt_n   = '0;
            end
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state   <= IDLE;
         GNT     <= '0;
         BUSY    <= 1'b0;
         DET_CLR <= 1'b0;
         OWNER   <= 3'd0;
         ptr     <= 3'd0;
         cnt     <= '0;
      end else begin
         state   <= state_n;
         GNT     <= gnt_n;
         BUSY    <= busy_n;
         DET_CLR <= clr_n;
         OWNER   <= owner_n;
         ptr     <= ptr_n;
         cnt     <= cnt_n;
      end
   end

endmodule

// File: tb/tb_detector_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_detector_share_arbiter
//
// Self-checking bench for detector_share_arbiter (NUM_REQ=4, MAX_HOLD=8).
// Each scenario task pushes the expected outputs for a cycle into a scoreboard
// queue as it drives that cycle's stimulus, then pops and compares once the
// clock edge has produced the DUT response.
// -----------------------------------------------------------------------------
module tb_detector_share_arbiter;

   logic       CLK;
   logic       RST;
   logic [3:0] REQ;
   logic [3:0] BIT_IN;
   logic       LOCK;
   logic [3:0] GNT;
   logic       BUSY;
   logic       DET_IN;
   logic       DET_CLR;
   logic [2:0] OWNER;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [3:0] gnt;
      logic       busy;
      logic       clr;
      logic       det;
      logic [2:0] own;
   } exp_t;

   exp_t       sb[$];
   logic [2:0] last_owner = 3'd0;

   detector_share_arbiter #(
      .NUM_REQ (4),
      .MAX_HOLD(8),
      .CNT_W   (8)
   ) dut (
      .CLK    (CLK),
      .RST    (RST),
      .REQ    (REQ),
      .BIT_IN (BIT_IN),
      .LOCK   (LOCK),
      .GNT    (GNT),
      .BUSY   (BUSY),
      .DET_IN (DET_IN),
      .DET_CLR(DET_CLR),
      .OWNER  (OWNER)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, got running sim, want finished");
      $fatal(1, "watchdog");
   end

   // Expected-value entry; owner follows the grant, or holds the last owner.
   task automatic push_exp(input logic [3:0] g, input logic c, input logic d);
      exp_t e;
      for (int i = 0; i < 4; i++) if (g[i]) last_owner = 3'(i);
      e.gnt  = g;
      e.busy = |g;
      e.clr  = c;
      e.det  = d;
      e.own  = last_owner;
      sb.push_back(e);
   endtask

   // Apply one cycle of stimulus and step to just after the next rising edge.
   task automatic drive(input logic [3:0] r, input logic [3:0] b, input logic l);
      REQ    = r;
      BIT_IN = b;
      LOCK   = l;
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      exp_t e;
      #2;
      checks++;
      if (GNT !== 4'b0 || BUSY !== 1'b0 || DET_CLR !== 1'b0 || DET_IN !== 1'b0 || OWNER !== 3'd0) begin
         errors++;
         $display("FAIL reset_init: got gnt=%b busy=%b clr=%b det=%b own=%0d want all zero",
                  GNT, BUSY, DET_CLR, DET_IN, OWNER);
      end
      repeat (2) @(posedge CLK);
      #1;
      RST = 1'b1;
      last_owner = 3'd0;
      for (int i = 0; i < 5; i++) begin
         logic [3:0] r = (i < 3) ? 4'b0000 : 4'b0010;
         logic [3:0] g = (i < 3) ? 4'b0000 : 4'b0010;
         push_exp(g, (i == 3), |(4'b1111 & g));
         drive(r, 4'b1111, 1'b0);
         e = sb.pop_front();
         checks++;
         if ({GNT, BUSY, DET_CLR, DET_IN, OWNER} !== e) begin
            errors++;
            $display("FAIL reset cyc %0d: got gnt=%b busy=%b clr=%b det=%b own=%0d want gnt=%b busy=%b clr=%b det=%b own=%0d",
                     i, GNT, BUSY, DET_CLR, DET_IN, OWNER, e.gnt, e.busy, e.clr, e.det, e.own);
         end
      end
      // Asynchronous reset in the middle of the grant to requester 1.
      #2;
      RST = 1'b0;
      REQ = 4'b0000;
      #1;
      checks++;
      if (GNT !== 4'b0 || BUSY !== 1'b0 || DET_CLR !== 1'b0 || DET_IN !== 1'b0 || OWNER !== 3'd0) begin
         errors++;
         $display("FAIL reset_midgrant: got gnt=%b busy=%b clr=%b det=%b own=%0d want all zero",
                  GNT, BUSY, DET_CLR, DET_IN, OWNER);
      end
      @(posedge CLK);
      #1;
      RST = 1'b1;
      last_owner = 3'd0;
      for (int i = 0; i < 3; i++) begin
         push_exp(4'b0000, 1'b0, 1'b0);
         drive(4'b0000, 4'b1111, 1'b0);
         e = sb.pop_front();
         checks++;
         if ({GNT, BUSY, DET_CLR, DET_IN, OWNER} !== e) begin
            errors++;
            $display("FAIL reset_idle cyc %0d: got gnt=%b busy=%b clr=%b det=%b own=%0d want gnt=%b busy=%b clr=%b det=%b own=%0d",
                     i, GNT, BUSY, DET_CLR, DET_IN, OWNER, e.gnt, e.busy, e.clr, e.det, e.own);
         end
      end
   endtask

   // Pointer is 0 here; a 3-cycle grant to requester 2 must move it to 3.
   task automatic test_single();
      exp_t       e;
      logic [3:0] bits;
      logic [3:0] reqs[8] = '{4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 4'b0000};
      logic [3:0] gnts[8] = '{4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0000};
      logic       clrs[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 8; i++) begin
         bits = 4'($urandom);
         push_exp(gnts[i], clrs[i], |(bits & gnts[i]));
         drive(reqs[i], bits, 1'b0);
         e = sb.pop_front();
         checks++;
         if ({GNT, BUSY, DET_CLR, DET_IN, OWNER} !== e) begin
            errors++;
            $display("FAIL single cyc %0d: got gnt=%b busy=%b clr=%b det=%b own=%0d want gnt=%b busy=%b clr=%b det=%b own=%0d",
                     i, GNT, BUSY, DET_CLR, DET_IN, OWNER, e.gnt, e.busy, e.clr, e.det, e.own);
         end
      end
   endtask

   // All four requesting: 8-cycle grants rotating 0,1,2,3,0 with one GAP each.
   task automatic test_rotation();
      exp_t       e;
      logic [3:0] bits;
      logic [3:0] g;
      for (int n = 0; n < 5; n++) begin
         for (int c = 0; c < 9; c++) begin
            bits = 4'($urandom);
            g    = (c < 8) ? (4'b0001 << (n % 4)) : 4'b0000;
            push_exp(g, (c == 0), |(bits & g));
            drive(4'b1111, bits, 1'b0);
            e = sb.pop_front();
            checks++;
            if ({GNT, BUSY, DET_CLR, DET_IN, OWNER} !== e) begin
               errors++;
               $display("FAIL rotation grant %0d cyc %0d: got gnt=%b busy=%b clr=%b det=%b own=%0d want gnt=%b busy=%b clr=%b det=%b own=%0d",
                        n, c, GNT, BUSY, DET_CLR, DET_IN, OWNER, e.gnt, e.busy, e.clr, e.det, e.own);
            end
         end
      end
      push_exp(4'b0000, 1'b0, 1'b0);
      drive(4'b0000, 4'b1111, 1'b0);
      e = sb.pop_front();
      checks++;
      if ({GNT, BUSY, DET_CLR, DET_IN, OWNER} !== e) begin
         errors++;
         $display("FAIL rotation idle: got gnt=%b busy=%b clr=%b det=%b own=%0d want gnt=%b busy=%b clr=%b det=%b own=%0d",
                  GNT, BUSY, DET_CLR, DET_IN, OWNER, e.gnt, e.busy, e.clr, e.det, e.own);
      end
   endtask

   // Requester 2 owns; its bit runs 1,0,0,1 while the other lines toggle.
   task automatic test_steering();
      exp_t       e;
      logic [3:0] reqs[6] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
      logic [3:0] bits[6] = '{4'b0101, 4'b1011, 4'b0000, 4'b1111, 4'b1111, 4'b1111};
      logic [3:0] gnts[6] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
      logic       clrs[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      logic       dets[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 6; i++) begin
         push_exp(gnts[i], clrs[i], dets[i]);
         drive(reqs[i], bits[i], 1'b0);
         e = sb.pop_front();
         checks++;
         if ({GNT, BUSY, DET_CLR, DET_IN, OWNER} !== e) begin
            errors++;
            $display("FAIL steering cyc %0d: got gnt=%b busy=%b clr=%b det=%b own=%0d want gnt=%b busy=%b clr=%b det=%b own=%0d",
                     i, GNT, BUSY, DET_CLR, DET_IN, OWNER, e.gnt, e.busy, e.clr, e.det, e.own);
         end
      end
   endtask

   // Owner 3 drops on the same edge its hold expires; 0 and 1 request at that
   // edge. One GAP, then requester 0 wins (pointer advanced by exactly one).
   task automatic test_simul_release();
      exp_t       e;
      logic [3:0] bits;
      logic [3:0] r, g;
      for (int i = 0; i < 12; i++) begin
         bits = 4'($urandom);
         r = (i < 8) ? 4'b1001 : (i < 10) ? 4'b0011 : 4'b0000;
         g = (i < 8) ? 4'b1000 : (i == 9) ? 4'b0001 : 4'b0000;
         push_exp(g, (i == 0) || (i == 9), |(bits & g));
         drive(r, bits, 1'b0);
         e = sb.pop_front();
         checks++;
         if ({GNT, BUSY, DET_CLR, DET_IN, OWNER} !== e) begin
            errors++;
            $display("FAIL simul_release cyc %0d: got gnt=%b busy=%b clr=%b det=%b own=%0d want gnt=%b busy=%b clr=%b det=%b own=%0d",
                     i, GNT, BUSY, DET_CLR, DET_IN, OWNER, e.gnt, e.busy, e.clr, e.det, e.own);
         end
      end
   endtask

   // Short grant to 1 moves the pointer to 2, then REQ=0011 with LOCK high.
   task automatic test_lock();
      exp_t       e;
      logic [3:0] bits;
      logic [3:0] r, g;
      logic       c, l;
      for (int i = -2; i < 18; i++) begin
         bits = 4'($urandom);
         if (i < 0) begin
            r = (i == -2) ? 4'b0010 : 4'b0000;
            g = r;
            c = (i == -2);
            l = 1'b0;
         end else begin
            r = (i < 16) ? 4'b0011 : 4'b0000;
            l = (i < 12);
`ifdef ARB_LOCK_EN
            g = (i < 12) ? 4'b0001 : (i == 12) ? 4'b0000 : (i < 16) ? 4'b0010 : 4'b0000;
            c = (i == 0) || (i == 13);
`else
            g = (i < 8) ? 4'b0001 : (i == 8) ? 4'b0000 : (i < 16) ? 4'b0010 : 4'b0000;
            c = (i == 0) || (i == 9);
`endif
         end
         push_exp(g, c, |(bits & g));
         drive(r, bits, l);
         e = sb.pop_front();
         checks++;
         if ({GNT, BUSY, DET_CLR, DET_IN, OWNER} !== e) begin
            errors++;
            $display("FAIL lock cyc %0d: got gnt=%b busy=%b clr=%b det=%b own=%0d want gnt=%b busy=%b clr=%b det=%b own=%0d",
                     i, GNT, BUSY, DET_CLR, DET_IN, OWNER, e.gnt, e.busy, e.clr, e.det, e.own);
         end
      end
   endtask

   initial begin
      RST    = 1'b0;
      REQ    = 4'b0000;
      BIT_IN = 4'b0000;
      LOCK   = 1'b0;
      test_reset();
      test_single();
      test_rotation();
      test_steering();
      test_simul_release();
      test_lock();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/detector_share_arbiter.md
Name: detector_share_arbiter

Overview:
- Round-robin arbiter that time-shares one serial sequence-detector FSM between NUM_REQ requesters.
- Each requester drives its own serial bit line. The arbiter grants one requester at a time and steers that requester's bit onto the detector input.
- It clears the detector at the start of every grant and caps each grant at MAX_HOLD cycles, so no requester can starve the others.
- Sits between the requester front-ends and the shared detector instance.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- MAX_HOLD, 8, maximum consecutive cycles in one grant; legal range 2..255.
- CNT_W, 8, hold-counter width; must satisfy 2**CNT_W > MAX_HOLD.

Ports:
- CLK  input  1  single clock, rising-edge.
- RST  input  1  asynchronous active-low reset (0 = reset).
- REQ  input  NUM_REQ  per-requester request level; held high while the requester wants the detector.
- BIT_IN  input  NUM_REQ  per-requester serial bit.
- LOCK  input  1  grant-extension request; only used when ARB_LOCK_EN is defined.
- GNT  output  NUM_REQ  one-hot registered grant.
- BUSY  output  1  high while any grant is active.
- DET_IN  output  1  steered serial bit to the shared detector.
- DET_CLR  output  1  one-cycle clear pulse to the detector, registered.
- OWNER  output  3  binary index of the current or last owner.

Behaviour:
- Clock and reset: one clock, CLK. Reset RST is asynchronous and active-low.
- Reset values (immediate on RST=0, including mid-grant): state IDLE, GNT=0, BUSY=0, DET_CLR=0, OWNER=0, priority pointer PTR=0, hold counter=0.
- DET_IN is combinational: BIT_IN[OWNER] when BUSY=1, otherwise 0. It is 0 during reset.
- Selection: the winner is the first requester with REQ=1 searching PTR, PTR+1, ... modulo NUM_REQ.
- States:
  - IDLE: if any REQ=1 at the edge, go to GRANT. On that edge load GNT (one-hot winner), OWNER, BUSY=1, DET_CLR=1, counter=1. If no REQ, stay in IDLE with all outputs low.
  - GRANT: DET_CLR=1 only in the first GRANT cycle, then 0. The counter increments each cycle.
    - Exit at the edge where REQ[OWNER]=0, or counter==MAX_HOLD.
    - On exit go to GAP: GNT=0, BUSY=0, PTR=(OWNER+1) mod NUM_REQ.
  - GAP: exactly one cycle with all grants low, so the detector sees an idle cycle. Next edge behaves as IDLE, using the updated PTR; this allows back-to-back grants.
- Latency: REQ sampled high in IDLE gives GNT high on the following edge, i.e. 1 cycle.
- Hold limit: a continuously requesting owner gets exactly MAX_HOLD grant cycles, then 1 GAP cycle.
  - It regains the grant only after all higher-rotation requesters have been served.
  - If it is the only requester, it regains the grant immediately after GAP.
- Simultaneous events:
  - REQ[OWNER] drops on the same edge the counter reaches MAX_HOLD: a single exit to GAP; PTR advances once.
  - REQ changes during GAP: sampled at the GAP-to-next edge only.
  - Requests from non-owners during GRANT have no effect until GAP.
- A new REQ from a requester arriving in the same cycle as the owner's release still waits for the GAP cycle.
- GNT is always one-hot or zero. BUSY equals OR of GNT.
- Counter saturates at MAX_HOLD and never wraps.

Optional Feature:
- Macro ARB_LOCK_EN.
- Defined: while LOCK=1 and REQ[OWNER]=1, the MAX_HOLD exit is suppressed.
  - The counter saturates at MAX_HOLD.
  - When LOCK falls with counter==MAX_HOLD, exit to GAP on that edge.
  - Release on REQ[OWNER]=0 is unaffected.
- Not defined: the LOCK port exists but is ignored; MAX_HOLD is always enforced.

Test Plan:
- Reset: assert RST=0 mid-grant with GNT=4'b0010 -> GNT=0, BUSY=0, DET_IN=0 immediately; after release with REQ=0, IDLE persists.
- Single request: REQ=4'b0100 held 3 cycles then dropped -> GNT=4'b0100 one cycle after REQ, DET_CLR=1 for the first cycle only; 3 grant cycles, then GAP; PTR=3.
- Rotation: REQ=4'b1111 held, MAX_HOLD=8 -> grants 0001, 0010, 0100, 1000, 0001, each 8 cycles long, with a one-cycle all-zero GAP between them.
- Steering: grant to requester 2, BIT_IN[2] pattern 1,0,0,1 with other bits toggling -> DET_IN follows 1,0,0,1 exactly; DET_IN=0 in the GAP cycle.
- Simultaneous release: REQ[OWNER] drops on cycle 8 with MAX_HOLD=8 -> exactly one GAP; PTR advances by 1, not 2.
- ARB_LOCK_EN: LOCK=1, REQ=4'b0011, owner 0 -> grant exceeds 8 cycles; LOCK drop at cycle 12 -> GAP, then GNT=4'b0010. Without the macro, the same stimulus gives an 8-cycle grant.
